// File: rtl/ncl_pkg.sv
// Shared four-rail NCL definitions: rail count, NULL code, handshake states
// and the 1-of-4 code decoder used by the clocked sink.
package ncl_pkg;

  localparam int NCL_RAILS = 4;
  localparam logic [NCL_RAILS-1:0] NCL_NULL = 4'b0000;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } ncl_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } ncl_dec_t;

  // valid is set only for exactly one rail high; idx is that rail's number
  function automatic ncl_dec_t ncl_decode(input logic [NCL_RAILS-1:0] code);
    ncl_dec_t r;
    r.valid = 1'b1;
    r.idx   = 2'd0;
    case (code)
      4'b0001: r.idx = 2'd0;
      4'b0010: r.idx = 2'd1;
      4'b0100: r.idx = 2'd2;
      4'b1000: r.idx = 2'd3;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ncl_sync_vec.sv
// Multi-flop synchroniser for an asynchronous rail vector, cleared by init.
module ncl_sync_vec #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/ncl4_sync_sink.sv
// Clocked sink for a 1-of-4 NCL pipeline: synchronises and filters the rails,
// captures DATA tokens into a valid/ready register and drives completion back.
module ncl4_sync_sink
  import ncl_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic [NCL_RAILS-1:0] rail_in,
  output logic                 ack_out,
  output logic [1:0]           dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 err,
  output logic [CNT_W-1:0]     tok_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [NCL_RAILS-1:0] s;
  logic [NCL_RAILS-1:0] prev_q, prev_d;
  logic [CW-1:0]        cnt_q, cnt_d, run_cnt;
  ncl_state_e           state_q, state_d;
  logic                 ack_q, ack_d;
  logic [1:0]           dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     tok_count_q, tok_count_d;
  ncl_dec_t             dec;
  logic                 multi_hot, stable, slot_free;

  ncl_sync_vec #(
    .WIDTH (NCL_RAILS),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .init(init),
    .d   (rail_in),
    .q   (s)
  );

  always_comb begin
    dec       = ncl_decode(s);
    multi_hot = (s != NCL_NULL) && !dec.valid;
    // run_cnt includes the current cycle, so a fresh code counts as one sample
    if (s != prev_q) begin
      run_cnt = CW'(1);
    end else if (cnt_q == CW'(STABLE_CYCLES)) begin
      run_cnt = cnt_q;
    end else begin
      run_cnt = cnt_q + CW'(1);
    end
    stable    = (run_cnt >= CW'(STABLE_CYCLES));
    slot_free = !dout_valid_q || dout_ready;

    prev_d       = s;
    cnt_d        = run_cnt;
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !dout_ready;
    err_d        = err_q;
    tok_count_d  = tok_count_q;

    case (state_q)
      WAIT_DATA: begin
        if (stable) begin
          if (dec.valid && slot_free) begin
            dout_d       = dec.idx;
            dout_valid_d = 1'b1;
            tok_count_d  = tok_count_q + CNT_W'(1);
            state_d      = WAIT_NULL;
          end else if (multi_hot) begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_NULL: begin
        // dout_q still names the token being acknowledged here
        if (stable) begin
          if (s == NCL_NULL) begin
            state_d = WAIT_DATA;
          end else if (multi_hot || (dec.valid && (dec.idx != dout_q))) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_DATA;
    endcase

    ack_d = (state_d == WAIT_NULL);
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      prev_q       <= NCL_NULL;
      cnt_q        <= '0;
      state_q      <= WAIT_DATA;
      ack_q        <= 1'b0;
      dout_q       <= 2'd0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
      tok_count_q  <= '0;
    end else begin
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      ack_q        <= ack_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
      tok_count_q  <= tok_count_d;
    end
  end

  assign ack_out    = ack_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign err        = err_q;
  assign tok_count  = tok_count_q;

endmodule

// File: tb/tb_ncl4_sync_sink.sv
// Directed bench for ncl4_sync_sink; a second narrow-counter instance covers wrap.
module tb_ncl4_sync_sink;

  logic        clk = 1'b0;
  logic        init = 1'b0;
  logic [3:0]  rail_in = 4'b0000;
  logic        dout_ready = 1'b1;
  logic        ack_out, dout_valid, err;
  logic [1:0]  dout;
  logic [15:0] tok_count;

  logic [3:0]  rail_w = 4'b0000;
  logic        ready_w = 1'b1;
  logic        ack_w, valid_w, err_w;
  logic [1:0]  dout_w;
  logic [2:0]  tok_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ncl4_sync_sink #(.SYNC_STAGES(2), .STABLE_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .init(init), .rail_in(rail_in), .ack_out(ack_out),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err(err), .tok_count(tok_count)
  );

  ncl4_sync_sink #(.SYNC_STAGES(2), .STABLE_CYCLES(2), .CNT_W(3)) dut_w (
    .clk(clk), .init(init), .rail_in(rail_w), .ack_out(ack_w),
    .dout(dout_w), .dout_valid(valid_w), .dout_ready(ready_w),
    .err(err_w), .tok_count(tok_w)
  );

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Wait (bounded) for an acknowledge line of either instance to reach a level
  task automatic wait_ack(input logic narrow, input logic want, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if ((narrow ? ack_w : ack_out) === want) begin
        ok = 1'b1;
        break;
      end
      edges(1);
    end
  endtask

  task automatic test_reset();
    rail_in = 4'b0000;
    dout_ready = 1'b1;
    #1 init = 1'b1;
    #1;
    vectors++; if (ack_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack got %b expected 0", ack_out); end
    vectors++; if (dout !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_dout got %0d expected 0", dout); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b expected 0", dout_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b expected 0", err); end
    vectors++; if (tok_count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_tok got %0d expected 0", tok_count); end
    edges(2);
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic test_capture();
    @(negedge clk);
    rail_in = 4'b0100;
    edges(3);
    vectors++; if (ack_out !== 1'b0) begin miscompares++; $display("[TB] FAIL early_ack got %b expected 0", ack_out); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL early_valid got %b expected 0", dout_valid); end
    edges(1);
    vectors++; if (dout !== 2'd2) begin miscompares++; $display("[TB] FAIL cap_dout got %0d expected 2", dout); end
    vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_valid got %b expected 1", dout_valid); end
    vectors++; if (ack_out !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_ack got %b expected 1", ack_out); end
    vectors++; if (tok_count !== 16'd1) begin miscompares++; $display("[TB] FAIL cap_tok got %0d expected 1", tok_count); end
    edges(1);
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL consume_valid got %b expected 0", dout_valid); end
    @(negedge clk);
    rail_in = 4'b0000;
    edges(3);
    vectors++; if (ack_out !== 1'b1) begin miscompares++; $display("[TB] FAIL null_early_ack got %b expected 1", ack_out); end
    edges(1);
    vectors++; if (ack_out !== 1'b0) begin miscompares++; $display("[TB] FAIL null_ack got %b expected 0", ack_out); end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    rail_in = 4'b1000;
    @(negedge clk);
    rail_in = 4'b0000;
    edges(8);
    vectors++; if (ack_out !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_ack got %b expected 0", ack_out); end
    vectors++; if (tok_count !== 16'd1) begin miscompares++; $display("[TB] FAIL glitch_tok got %0d expected 1", tok_count); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_valid got %b expected 0", dout_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    dout_ready = 1'b0;
    rail_in = 4'b0010;
    edges(4);
    vectors++; if (dout !== 2'd1 || dout_valid !== 1'b1 || tok_count !== 16'd2) begin
      miscompares++; $display("[TB] FAIL bp_first got dout=%0d valid=%b tok=%0d expected 1 1 2", dout, dout_valid, tok_count); end
    @(negedge clk);
    rail_in = 4'b0000;
    edges(4);
    vectors++; if (ack_out !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_null_ack got %b expected 0", ack_out); end
    @(negedge clk);
    rail_in = 4'b0001;
    edges(8);
    vectors++; if (ack_out !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_hold_ack got %b expected 0", ack_out); end
    vectors++; if (dout !== 2'd1 || dout_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bp_hold_dout got dout=%0d valid=%b expected 1 1", dout, dout_valid); end
    vectors++; if (tok_count !== 16'd2) begin miscompares++; $display("[TB] FAIL bp_hold_tok got %0d expected 2", tok_count); end
    @(negedge clk);
    dout_ready = 1'b1;
    edges(1);
    vectors++; if (dout !== 2'd0 || dout_valid !== 1'b1 || ack_out !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bp_swap got dout=%0d valid=%b ack=%b expected 0 1 1", dout, dout_valid, ack_out); end
    vectors++; if (tok_count !== 16'd3) begin miscompares++; $display("[TB] FAIL bp_swap_tok got %0d expected 3", tok_count); end
    edges(1);
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain got %b expected 0", dout_valid); end
    @(negedge clk);
    rail_in = 4'b0000;
    edges(4);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    rail_in = 4'b0101;
    edges(8);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL multi_err got %b expected 1", err); end
    vectors++; if (dout_valid !== 1'b0 || ack_out !== 1'b0) begin
      miscompares++; $display("[TB] FAIL multi_capture got valid=%b ack=%b expected 0 0", dout_valid, ack_out); end
    vectors++; if (tok_count !== 16'd3) begin miscompares++; $display("[TB] FAIL multi_tok got %0d expected 3", tok_count); end
    @(negedge clk);
    rail_in = 4'b0000;
    edges(8);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_sticky got %b expected 1", err); end
    pulse_init();
    #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_clear got %b expected 0", err); end
  endtask

  // Upstream ring source: each lap advances the token to the next rail
  task automatic test_ring();
    logic ok;
    dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_ack(1'b0, 1'b0, ok);
      vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ring_req_timeout lap %0d got ack=%b expected 0", k, ack_out); end
      rail_in = 4'b0001 << (k % 4);
      wait_ack(1'b0, 1'b1, ok);
      vectors++; if (!ok || dout !== 2'(k % 4) || tok_count !== 16'(k + 1)) begin
        miscompares++; $display("[TB] FAIL ring_token lap %0d got ack=%b dout=%0d tok=%0d expected 1 %0d %0d", k, ack_out, dout, tok_count, k % 4, k + 1); end
      rail_in = 4'b0000;
    end
    wait_ack(1'b0, 1'b0, ok);
    vectors++; if (!ok || err !== 1'b0) begin miscompares++; $display("[TB] FAIL ring_end got ack=%b err=%b expected 0 0", ack_out, err); end
  endtask

  task automatic test_init_midhandshake();
    logic ok;
    rail_in = 4'b1000;
    wait_ack(1'b0, 1'b1, ok);
    vectors++; if (!ok || dout !== 2'd3 || dout_valid !== 1'b1 || tok_count !== 16'd9) begin
      miscompares++; $display("[TB] FAIL pre_init got ack=%b dout=%0d valid=%b tok=%0d expected 1 3 1 9", ack_out, dout, dout_valid, tok_count); end
    #3 init = 1'b1;
    #2;
    vectors++; if (ack_out !== 1'b0 || dout_valid !== 1'b0 || tok_count !== 16'd0 || dout !== 2'd0) begin
      miscompares++; $display("[TB] FAIL async_init got ack=%b valid=%b tok=%0d dout=%0d expected 0 0 0 0", ack_out, dout_valid, tok_count, dout); end
    @(negedge clk);
    init = 1'b0;
    wait_ack(1'b0, 1'b1, ok);
    vectors++; if (!ok || dout !== 2'd3 || tok_count !== 16'd1) begin
      miscompares++; $display("[TB] FAIL reeval got ack=%b dout=%0d tok=%0d expected 1 3 1", ack_out, dout, tok_count); end
    rail_in = 4'b0000;
    wait_ack(1'b0, 1'b0, ok);
  endtask

  task automatic test_wrap();
    logic ok;
    ready_w = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rail_w = 4'b0001 << (k % 4);
      wait_ack(1'b1, 1'b1, ok);
      vectors++; if (!ok || tok_w !== 3'((k + 1) % 8)) begin
        miscompares++; $display("[TB] FAIL wrap_tok token %0d got ack=%b tok=%0d expected 1 %0d", k, ack_w, tok_w, (k + 1) % 8); end
      rail_w = 4'b0000;
      wait_ack(1'b1, 1'b0, ok);
      vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL wrap_null token %0d got ack=%b expected 0", k, ack_w); end
    end
    vectors++; if (err_w !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_err got %b expected 0", err_w); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_glitch();
    test_backpressure();
    test_illegal();
    test_ring();
    test_init_midhandshake();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ncl4_sync_sink.md
# ncl4_sync_sink

Clocked consumer stage for a four-rail (1-of-4) NCL pipeline. It sits directly downstream of a four-rail pipe component, taking its Z rails and driving that component's ZCOMP completion input. It synchronises the rails into the clock domain, detects DATA and NULL wavefronts, and hands each 2-bit DATA token to clocked logic over a valid/ready interface. It acknowledges DATA only once the token is captured, so the pipeline ring is never overrun.

## Interface
- SYNC_STAGES, 2, flops in the rail synchroniser (≥2)
- STABLE_CYCLES, 2, consecutive identical synchronised samples required before a wavefront is accepted (≥1)
- CNT_W, 16, width of token counter
- clk  input  1  sampling clock
- init  input  1  reset; asynchronous, active-high
- rail_in  input  4  NCL four-rail data from the upstream component's Z; all-zero = NULL, exactly one rail high = DATA
- ack_out  output  1  completion to the upstream component's ZCOMP; 1 = DATA held (request NULL), 0 = NULL seen (request DATA)
- dout  output  2  decoded token value (index of high rail)
- dout_valid  output  1  dout holds an unconsumed token
- dout_ready  input  1  consumer accepts dout this cycle
- err  output  1  sticky illegal-code flag (more than one rail high, stable)
- tok_count  output  CNT_W  DATA tokens accepted since reset, wraps modulo 2^CNT_W

## Operation
- Rails pass through SYNC_STAGES flops; all later logic sees only the synchronised vector s.
- Stability filter: counter resets whenever s differs from its previous value. A code is "stable" when the same s has been seen STABLE_CYCLES consecutive cycles.
- FSM states:
  - WAIT_DATA (ack_out=0): stable one-hot s and output slot free (dout_valid=0, or dout_ready=1 this cycle) -> load dout with rail index (rail0->0 … rail3->3), set dout_valid, increment tok_count, go WAIT_NULL. Stable one-hot with slot occupied -> stay, no ack (backpressure into the ring). Stable multi-hot -> set err, stay, nothing captured. Stable zero -> stay.
  - WAIT_NULL (ack_out=1): stable all-zero s -> go WAIT_DATA. Stable multi-hot -> set err, stay. A different stable one-hot code without intervening NULL is also illegal: set err, stay, no capture.
- ack_out is a registered decode of state (1 only in WAIT_NULL).
- dout_valid clears on dout_valid & dout_ready unless a new token loads in the same cycle, in which case it stays 1 with the new value.
- dout holds its value while dout_valid=0.
- err clears only on init.

## Timing
- Reset (init=1, asynchronous): state WAIT_DATA; ack_out=0, dout=0, dout_valid=0, err=0, tok_count=0; synchroniser and stability counter cleared. Release is synchronous to the next clk edge.
- Rail edge to first appearance in s: SYNC_STAGES cycles. Stable accept: STABLE_CYCLES-1 further cycles.
- Capture on edge E: dout/dout_valid/tok_count/ack_out all update on E. Default worst-case rail->ack latency is SYNC_STAGES+STABLE_CYCLES cycles.
- NULL accepted on edge E: ack_out falls on E. The next DATA cannot be captured before E+STABLE_CYCLES.
- Simultaneous load and consume: the new token wins, with no bubble.
- init mid-handshake: ack_out drops immediately. Any token in dout is lost. The rail state at release is re-evaluated from WAIT_DATA.
- tok_count wrap: 2^CNT_W-1 -> 0, no flag.

## Structure
- Shared package ncl_pkg: NCL_RAILS=4 constant, NULL code 4'b0000, state enum (WAIT_DATA, WAIT_NULL), and a function returning one-hot valid and index for a 4-bit code.
- One sub-module: ncl_sync_vec (parameterised-width, SYNC_STAGES-deep synchroniser with async clear on init). FSM, filter and output register stay in the top.

## Test plan
- Reset then rail_in=4'b0100 held, dout_ready=1 -> after SYNC_STAGES+STABLE_CYCLES edges: dout=2, dout_valid=1, ack_out=1, tok_count=1. rail_in=0 -> ack_out=0 after the same delay.
- Full ring loopback with a 4-rail four-component ring model -> tokens arrive in rotating sequence 0,1,2,3,0…. err stays 0. tok_count tracks the token count exactly.
- dout_ready=0 with a token held, next DATA 4'b0001 presented -> ack_out stays 0 and dout unchanged. Raise dout_ready -> new dout=0 loads the same cycle the old token is consumed.
- rail_in=4'b0101 held -> err=1, dout_valid stays 0, tok_count unchanged. err remains 1 after rail_in returns to 0 until init.
- One-cycle glitch 4'b1000 (shorter than STABLE_CYCLES) on NULL rails -> no capture, ack_out stays 0.
- init asserted while ack_out=1 -> ack_out, dout_valid and tok_count go to 0 immediately without a clock edge. With tok_count preloaded near 0xFFFF by 65535 tokens, the next token wraps tok_count to 0.
